// File: rtl/serial_sub_n.sv
// serial_sub_n: bit-serial add/subtract unit.
// One bit pair is processed per clock, LSB first, after an operation is
// accepted in IDLE. The result is assembled in D from the MSB side so that,
// once WIDTH bits have been processed, D holds the result in natural order.
// Bout carries the final borrow (sub) or carry (add); V flags two's-complement
// overflow of the completed operation.

module serial_sub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  // Counter only needs to reach WIDTH-1; it is compared against LAST_BIT
  // rather than WIDTH so it never has to hold a value one past the end.
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic             cb_q, cb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             cb_next;
  logic             last_bit;

  // Single-bit full adder / full subtractor on the current operand LSBs.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    sum_bit  = a_bit ^ b_bit ^ cb_q;
    last_bit = (cnt_q == LAST_BIT);
    if (mode_q) begin
      cb_next = (a_bit & b_bit) | (cb_q & (a_bit ^ b_bit));
    end else begin
      cb_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & cb_q);
    end
  end

  // State and datapath registers; reset clears everything, including the
  // latched operands, and overrides any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      cb_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cb_q    <= cb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  // Next-state logic: DONE always lasts one cycle and start is only looked
  // at while IDLE, so requests during SHIFT/DONE are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: latch operands on acceptance, then shift one bit
  // per SHIFT cycle; the published flags only change on the final bit.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    cb_d   = cb_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    bout_d = bout_q;
    v_d    = v_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d    = A;
          b_d    = B;
          mode_d = mode;
          cb_d   = Bin;
          cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        cb_d  = cb_next;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          bout_d = cb_next;
          v_d    = cb_q ^ cb_next;
        end
      end
      default: begin
      end
    endcase
  end

  // Status outputs decoded purely from the state, so busy and done are
  // mutually exclusive by construction.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  assign D    = res_q;
  assign Bout = bout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_sub_n.sv
// tb_serial_sub_n: self-checking bench for serial_sub_n (WIDTH=8).
// Expected results come from plain integer arithmetic on the operands.

module tb_serial_sub_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
  logic         busy;
  logic         done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] obs_d;
  logic         obs_bout;
  logic         obs_v;
  logic         obs_overlap;
  int           obs_lat;
  int           obs_busy;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         m;
    logic [W-1:0] d;
    logic         bo;
    logic         v;
  } vec_t;

  vec_t vecs [0:5] = '{
    '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0},
    '{8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0},
    '{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1},
    '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  serial_sub_n #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .D    (D),
    .Bout (Bout),
    .V    (V),
    .busy (busy),
    .done (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference arithmetic: unsigned result for D/Bout, signed result for V.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bin, input logic m,
                                output logic [W-1:0] d, output logic bo,
                                output logic v);
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= (64'sd1 <<< (W - 1))) ? ua - (64'sd1 <<< W) : ua;
    sb = (ub >= (64'sd1 <<< (W - 1))) ? ub - (64'sd1 <<< W) : ub;
    if (m) begin
      ur = ua + ub + longint'(bin);
      sr = sa + sb + longint'(bin);
      bo = (ur >= (64'sd1 <<< W));
    end else begin
      ur = ua - ub - longint'(bin);
      sr = sa - sb - longint'(bin);
      bo = (ur < 0);
    end
    d = ur[W-1:0];
    v = (sr > ((64'sd1 <<< (W - 1)) - 1)) || (sr < -(64'sd1 <<< (W - 1)));
  endfunction

  // Runs one operation from IDLE and records what the DUT shows at done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic m,
                       input bit scramble, input bit pulse_start);
    @(negedge clk);
    A = a; B = b; Bin = bin; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_lat = 1;
    obs_busy = 0;
    obs_overlap = 1'b0;
    while (done !== 1'b1 && obs_lat < 4 * W + 8) begin
      if (busy === 1'b1) obs_busy++;
      if (scramble) begin
        A = W'($urandom); B = W'($urandom);
        Bin = 1'($urandom); mode = 1'($urandom);
      end
      if (pulse_start) start = 1'($urandom);
      @(negedge clk);
      obs_lat++;
    end
    start = 1'b0;
    obs_overlap = (busy === 1'b1) && (done === 1'b1);
    obs_d = D;
    obs_bout = Bout;
    obs_v = V;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 8'hA5; B = 8'h3C; Bin = 1'b1; mode = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (D !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_d: got %h expected 00", D); end
    n_cmp++; if (Bout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bout: got %b expected 0", Bout); end
    n_cmp++; if (V !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_v: got %b expected 0", V); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start_ignored: busy got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].m, 1'b0, 1'b0);
      n_cmp++; if (obs_lat !== W + 1) begin n_fail++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, obs_lat, W + 1); end
      n_cmp++; if (obs_busy !== W) begin n_fail++; $display("[TB] FAIL dir%0d_busy_cycles: got %0d expected %0d", i, obs_busy, W); end
      n_cmp++; if (obs_overlap !== 1'b0) begin n_fail++; $display("[TB] FAIL dir%0d_busy_done_overlap: got %b expected 0", i, obs_overlap); end
      n_cmp++; if (obs_d !== vecs[i].d) begin n_fail++; $display("[TB] FAIL dir%0d_d: got %h expected %h", i, obs_d, vecs[i].d); end
      n_cmp++; if (obs_bout !== vecs[i].bo) begin n_fail++; $display("[TB] FAIL dir%0d_bout: got %b expected %b", i, obs_bout, vecs[i].bo); end
      n_cmp++; if (obs_v !== vecs[i].v) begin n_fail++; $display("[TB] FAIL dir%0d_v: got %b expected %b", i, obs_v, vecs[i].v); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, ed;
    logic bin, m, eb, ev;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); m = 1'($urandom);
      model(a, b, bin, m, ed, eb, ev);
      do_op(a, b, bin, m, 1'b0, 1'b0);
      n_cmp++; if (obs_lat !== W + 1) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, obs_lat, W + 1); end
      n_cmp++; if ({obs_d, obs_bout, obs_v} !== {ed, eb, ev}) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_result: a=%h b=%h bin=%b mode=%b got D=%h Bout=%b V=%b expected D=%h Bout=%b V=%b",
                 i, a, b, bin, m, obs_d, obs_bout, obs_v, ed, eb, ev);
      end
    end
  endtask

  task automatic test_hold();
    do_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom); mode = 1'($urandom);
      @(negedge clk);
      n_cmp++; if ({D, Bout, V, busy, done} !== {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL hold%0d: got D=%h Bout=%b V=%b busy=%b done=%b expected D=7f Bout=0 V=1 busy=0 done=0",
                 i, D, Bout, V, busy, done);
      end
    end
  endtask

  task automatic test_operand_stability();
    logic [W-1:0] a, b, ed;
    logic bin, m, eb, ev;
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); m = 1'($urandom);
      model(a, b, bin, m, ed, eb, ev);
      do_op(a, b, bin, m, 1'b1, 1'b0);
      n_cmp++; if ({obs_d, obs_bout, obs_v} !== {ed, eb, ev}) begin
        n_fail++;
        $display("[TB] FAIL stable%0d_result: got D=%h Bout=%b V=%b expected D=%h Bout=%b V=%b",
                 i, obs_d, obs_bout, obs_v, ed, eb, ev);
      end
    end
  endtask

  task automatic test_start_during_busy();
    logic [W-1:0] a, b, ed;
    logic bin, m, eb, ev;
    int extra;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); m = 1'($urandom);
      model(a, b, bin, m, ed, eb, ev);
      do_op(a, b, bin, m, 1'b0, 1'b1);
      n_cmp++; if ({obs_d, obs_bout, obs_v} !== {ed, eb, ev}) begin
        n_fail++;
        $display("[TB] FAIL pulse%0d_result: got D=%h Bout=%b V=%b expected D=%h Bout=%b V=%b",
                 i, obs_d, obs_bout, obs_v, ed, eb, ev);
      end
      extra = 0;
      for (int c = 0; c < W + 3; c++) begin
        @(negedge clk);
        if (busy === 1'b1 || done === 1'b1) extra++;
      end
      n_cmp++; if (extra !== 0) begin n_fail++; $display("[TB] FAIL pulse%0d_no_extra_op: got %0d active cycles expected 0", i, extra); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, ed;
    logic bin, m, eb, ev;
    int lat;
    repeat (2) @(negedge clk);
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom); m = 1'($urandom);
    A = a; B = b; Bin = bin; mode = m; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model(a, b, bin, m, ed, eb, ev);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b%0d_accept: busy got %b expected 1", k, busy); end
      lat = 1;
      while (done !== 1'b1 && lat < 4 * W + 8) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++; if (lat !== W + 1) begin n_fail++; $display("[TB] FAIL b2b%0d_latency: got %0d expected %0d", k, lat, W + 1); end
      n_cmp++; if ({D, Bout, V} !== {ed, eb, ev}) begin
        n_fail++;
        $display("[TB] FAIL b2b%0d_result: got D=%h Bout=%b V=%b expected D=%h Bout=%b V=%b", k, D, Bout, V, ed, eb, ev);
      end
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom); m = 1'($urandom);
      A = a; B = b; Bin = bin; mode = m;
      if (k == 2) start = 1'b0;
      @(negedge clk);
      n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b%0d_idle_gap: busy/done got %b%b expected 00", k, busy, done); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    A = 8'hFF; B = 8'h00; Bin = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_status: busy/done got %b%b expected 00", busy, done); end
    n_cmp++; if ({D, Bout, V} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL midrst_regs: got D=%h Bout=%b V=%b expected D=00 Bout=0 V=0", D, Bout, V);
    end
    seen = 0;
    for (int c = 0; c < 3 * W; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_operand_stability();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
